fa_triple_check: RTL and testbench

//  Registered ripple-carry adder built from full-adder cells in three coding styles:

---
 rtl/fa_pkg.sv | 11 +
 rtl/fa_triple_check_if.sv | 27 ++
 rtl/fa_cell.sv | 43 ++++
 rtl/fa_triple_check.sv | 95 +++++++++
 tb/tb_fa_triple_check.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fa_pkg.sv
// Shared constants for the triple-style full-adder block: cell style
// selectors and the widest legal operand.
package fa_pkg;

  localparam int FA_STYLE_DATAFLOW = 0;
  localparam int FA_STYLE_BEHAV    = 1;
  localparam int FA_STYLE_CASE     = 2;

  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/fa_triple_check_if.sv
// Operand / result bundle for fa_triple_check.
// master: the side that supplies operands and consumes results.
// slave : the adder itself.
interface fa_triple_check_if #(
  parameter int WIDTH = 1
) ();

  logic             in_vld;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_vld;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             mismatch;

  modport master (
    output in_vld, a, b, ci,
    input  out_vld, s, co, mismatch
  );

  modport slave (
    input  in_vld, a, b, ci,
    output out_vld, s, co, mismatch
  );

endinterface

// File: rtl/fa_cell.sv
// One-bit full adder, purely combinational. STYLE selects how the same
// equations are written so the three codings can be checked against each other.
module fa_cell
  import fa_pkg::*;
#(
  parameter int STYLE = FA_STYLE_DATAFLOW
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  generate
    if (STYLE == FA_STYLE_BEHAV) begin : g_behav
      // Arithmetic form: let the two-bit add produce carry and sum together.
      always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
      end
    end else if (STYLE == FA_STYLE_CASE) begin : g_case
      // Truth-table form indexed by {ci,a,b}; undefined codes yield X.
      always_comb begin
        {co, s} = 2'b00;
        case ({ci, a, b})
          3'b000:  {co, s} = 2'b00;
          3'b001:  {co, s} = 2'b01;
          3'b010:  {co, s} = 2'b01;
          3'b011:  {co, s} = 2'b10;
          3'b100:  {co, s} = 2'b01;
          3'b101:  {co, s} = 2'b10;
          3'b110:  {co, s} = 2'b10;
          3'b111:  {co, s} = 2'b11;
          default: {co, s} = 2'bxx;
        endcase
      end
    end else begin : g_dataflow
      assign s  = a ^ b ^ ci;
      assign co = (a & b) | (ci & (a ^ b));
    end
  endgenerate

endmodule

// File: rtl/fa_triple_check.sv
// Registered ripple-carry adder. The dataflow chain produces s/co; when
// FA_CROSSCHECK_EN is defined, behavioural and case-table shadow chains are
// also built and any disagreement with the dataflow chain raises mismatch.
// With FA_CROSSCHECK_EN undefined only the dataflow chain exists and
// mismatch is always 0. Latency is one cycle in both builds.
module fa_triple_check
  import fa_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic              clk,
  input logic              rst_n,
  fa_triple_check_if.slave bus
);

  logic [WIDTH-1:0] df_s_s;
  logic [WIDTH:0]   df_c_s;
  logic             mismatch_s;

  logic             out_vld_r;
  logic [WIDTH-1:0] s_r;
  logic             co_r;
  logic             mismatch_r;

  assign df_c_s[0] = bus.ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_df
    fa_cell #(.STYLE(FA_STYLE_DATAFLOW)) u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (df_c_s[i]),
      .s  (df_s_s[i]),
      .co (df_c_s[i+1])
    );
  end

`ifdef FA_CROSSCHECK_EN
  logic [WIDTH-1:0] bh_s_s;
  logic [WIDTH:0]   bh_c_s;
  logic [WIDTH-1:0] cs_s_s;
  logic [WIDTH:0]   cs_c_s;

  assign bh_c_s[0] = bus.ci;
  assign cs_c_s[0] = bus.ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bh
    fa_cell #(.STYLE(FA_STYLE_BEHAV)) u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (bh_c_s[i]),
      .s  (bh_s_s[i]),
      .co (bh_c_s[i+1])
    );
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cs
    fa_cell #(.STYLE(FA_STYLE_CASE)) u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (cs_c_s[i]),
      .s  (cs_s_s[i]),
      .co (cs_c_s[i+1])
    );
  end

  // Any shadow chain differing from the reference chain is a disagreement.
  assign mismatch_s = ({bh_c_s[WIDTH], bh_s_s} != {df_c_s[WIDTH], df_s_s}) |
                      ({cs_c_s[WIDTH], cs_s_s} != {df_c_s[WIDTH], df_s_s});
`else
  assign mismatch_s = 1'b0;
`endif

  // Output stage: capture a fresh result on in_vld, otherwise hold data and drop out_vld.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_r  <= 1'b0;
      s_r        <= {WIDTH{1'b0}};
      co_r       <= 1'b0;
      mismatch_r <= 1'b0;
    end else if (bus.in_vld) begin
      out_vld_r  <= 1'b1;
      s_r        <= df_s_s;
      co_r       <= df_c_s[WIDTH];
      mismatch_r <= mismatch_s;
    end else begin
      out_vld_r  <= 1'b0;
    end
  end

  assign bus.out_vld  = out_vld_r;
  assign bus.s        = s_r;
  assign bus.co       = co_r;
  assign bus.mismatch = mismatch_r;

endmodule

// File: tb/tb_fa_triple_check.sv
// Self-checking bench for fa_triple_check: one WIDTH=1 and one WIDTH=4
// instance. Expected {co,s} values come from an arithmetic model, queued
// when operands are driven and popped when the result is due.
module tb_fa_triple_check;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [1:0] q1[$];   // {co,s} for WIDTH=1
  logic [4:0] q4[$];   // {co,s} for WIDTH=4

  fa_triple_check_if #(.WIDTH(1)) if1 ();
  fa_triple_check_if #(.WIDTH(4)) if4 ();

  fa_triple_check #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  fa_triple_check #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one WIDTH=4 operand set; queue its expected result when valid.
  task automatic send4(input logic vld, input logic [3:0] a, input logic [3:0] b, input logic ci);
    if4.in_vld = vld;
    if4.a      = a;
    if4.b      = b;
    if4.ci     = ci;
    if (vld) q4.push_back({1'b0, a} + {1'b0, b} + {4'b0000, ci});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if1.in_vld = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.ci = 1'b1;
    if4.in_vld = 1'b1; if4.a = 4'hF; if4.b = 4'hF; if4.ci = 1'b1;
    repeat (2) tick();
    n_checks++; if (if1.out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld1 got=%b exp=0", if1.out_vld); end
    n_checks++; if (if1.s !== 1'b0) begin n_fail++; $display("FAIL reset_s1 got=%b exp=0", if1.s); end
    n_checks++; if (if1.co !== 1'b0) begin n_fail++; $display("FAIL reset_co1 got=%b exp=0", if1.co); end
    n_checks++; if (if1.mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mm1 got=%b exp=0", if1.mismatch); end
    n_checks++; if (if4.out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld4 got=%b exp=0", if4.out_vld); end
    n_checks++; if (if4.s !== 4'h0) begin n_fail++; $display("FAIL reset_s4 got=%h exp=0", if4.s); end
    n_checks++; if (if4.co !== 1'b0) begin n_fail++; $display("FAIL reset_co4 got=%b exp=0", if4.co); end
    if1.in_vld = 1'b0;
    if4.in_vld = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep_w1();
    logic [2:0] v;
    logic [1:0] e;
    for (int k = 0; k < 8; k++) begin
      v = k[2:0];
      if1.ci = v[2]; if1.a = v[1]; if1.b = v[0]; if1.in_vld = 1'b1;
      q1.push_back({1'b0, v[1]} + {1'b0, v[0]} + {1'b0, v[2]});
      tick();
      e = q1.pop_front();
      n_checks++; if (if1.out_vld !== 1'b1) begin n_fail++; $display("FAIL sweep_vld k=%0d got=%b exp=1", k, if1.out_vld); end
      n_checks++; if (if1.s !== e[0]) begin n_fail++; $display("FAIL sweep_s k=%0d got=%b exp=%b", k, if1.s, e[0]); end
      n_checks++; if (if1.co !== e[1]) begin n_fail++; $display("FAIL sweep_co k=%0d got=%b exp=%b", k, if1.co, e[1]); end
      n_checks++; if (if1.mismatch !== 1'b0) begin n_fail++; $display("FAIL sweep_mm k=%0d got=%b exp=0", k, if1.mismatch); end
    end
    if1.in_vld = 1'b0;
    tick();
  endtask

  task automatic test_wrap_w4();
    logic [3:0] ta[3];
    logic [3:0] tb[3];
    logic       tc[3];
    logic [4:0] e;
    ta[0] = 4'hF; tb[0] = 4'h1; tc[0] = 1'b0;
    ta[1] = 4'h5; tb[1] = 4'hA; tc[1] = 1'b1;
    ta[2] = 4'hF; tb[2] = 4'hF; tc[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send4(1'b1, ta[k], tb[k], tc[k]);
      tick();
      e = q4.pop_front();
      n_checks++; if (if4.out_vld !== 1'b1) begin n_fail++; $display("FAIL wrap_vld k=%0d got=%b exp=1", k, if4.out_vld); end
      n_checks++; if (if4.s !== e[3:0]) begin n_fail++; $display("FAIL wrap_s k=%0d got=%h exp=%h", k, if4.s, e[3:0]); end
      n_checks++; if (if4.co !== e[4]) begin n_fail++; $display("FAIL wrap_co k=%0d got=%b exp=%b", k, if4.co, e[4]); end
    end
    send4(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
  endtask

  task automatic test_hold_w4();
    logic [4:0] e;
    send4(1'b1, 4'h3, 4'h4, 1'b0);
    tick();
    e = q4.pop_front();
    n_checks++; if (if4.s !== e[3:0]) begin n_fail++; $display("FAIL hold_first_s got=%h exp=%h", if4.s, e[3:0]); end
    send4(1'b0, 4'h9, 4'h9, 1'b1);
    tick();
    n_checks++; if (if4.out_vld !== 1'b0) begin n_fail++; $display("FAIL hold_vld got=%b exp=0", if4.out_vld); end
    n_checks++; if (if4.s !== 4'h7) begin n_fail++; $display("FAIL hold_s got=%h exp=7", if4.s); end
    n_checks++; if (if4.co !== 1'b0) begin n_fail++; $display("FAIL hold_co got=%b exp=0", if4.co); end
  endtask

  task automatic test_back_to_back();
    logic       vld;
    logic [4:0] e;
    logic [4:0] last;
    last = {if4.co, if4.s};
    for (int k = 0; k < 32; k++) begin
      vld = (k < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      send4(vld, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      tick();
      n_checks++; if (if4.out_vld !== vld) begin n_fail++; $display("FAIL b2b_vld k=%0d got=%b exp=%b", k, if4.out_vld, vld); end
      if (vld) begin
        e = q4.pop_front();
        last = e;
      end
      n_checks++; if ({if4.co, if4.s} !== last) begin n_fail++; $display("FAIL b2b_res k=%0d got=%h exp=%h", k, {if4.co, if4.s}, last); end
      n_checks++; if (if4.mismatch !== 1'b0) begin n_fail++; $display("FAIL b2b_mm k=%0d got=%b exp=0", k, if4.mismatch); end
    end
    send4(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [4:0] e;
    send4(1'b1, 4'hF, 4'hF, 1'b1);
    tick();
    e = q4.pop_front();
    n_checks++; if ({if4.co, if4.s} !== e) begin n_fail++; $display("FAIL mid_pre got=%h exp=%h", {if4.co, if4.s}, e); end
    rst_n = 1'b0;
    if4.in_vld = 1'b1; if4.a = 4'h1; if4.b = 4'h1; if4.ci = 1'b1;
    tick();
    n_checks++; if (if4.out_vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld got=%b exp=0", if4.out_vld); end
    n_checks++; if (if4.s !== 4'h0) begin n_fail++; $display("FAIL mid_s got=%h exp=0", if4.s); end
    n_checks++; if (if4.co !== 1'b0) begin n_fail++; $display("FAIL mid_co got=%b exp=0", if4.co); end
    rst_n = 1'b1;
    send4(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
  endtask

  task automatic test_crosscheck();
    logic [4:0] e;
`ifdef FA_CROSSCHECK_EN
    send4(1'b1, 4'h0, 4'h0, 1'b0);
    force dut4.cs_s_s = 4'b0001;
    tick();
    e = q4.pop_front();
    n_checks++; if (if4.mismatch !== 1'b1) begin n_fail++; $display("FAIL xchk_flag got=%b exp=1", if4.mismatch); end
    n_checks++; if ({if4.co, if4.s} !== e) begin n_fail++; $display("FAIL xchk_res got=%h exp=%h", {if4.co, if4.s}, e); end
    release dut4.cs_s_s;
    send4(1'b1, 4'h0, 4'h0, 1'b0);
    tick();
    e = q4.pop_front();
    n_checks++; if (if4.mismatch !== 1'b0) begin n_fail++; $display("FAIL xchk_clear got=%b exp=0", if4.mismatch); end
`else
    for (int k = 0; k < 4; k++) begin
      send4(1'b1, 4'(k * 5), 4'(15 - k), k[0]);
      tick();
      e = q4.pop_front();
      n_checks++; if (if4.mismatch !== 1'b0) begin n_fail++; $display("FAIL xchk_off k=%0d got=%b exp=0", k, if4.mismatch); end
      n_checks++; if ({if4.co, if4.s} !== e) begin n_fail++; $display("FAIL xchk_res k=%0d got=%h exp=%h", k, {if4.co, if4.s}, e); end
    end
`endif
    send4(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if1.in_vld = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.ci = 1'b0;
    if4.in_vld = 1'b0; if4.a = 4'h0; if4.b = 4'h0; if4.ci = 1'b0;
    #2;
    test_reset();
    test_sweep_w1();
    test_wrap_w4();
    test_hold_w4();
    test_back_to_back();
    test_reset_midstream();
    test_crosscheck();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
